// File: rtl/synth_pkg.sv
// Shared types and widths for the clk32 synthesis datapath: field widths,
// allocator FSM states and the per-voice record.
package synth_pkg;

    localparam int NOTE_W    = 7;
    localparam int VEL_W     = 7;
    localparam int CH_W      = 4;
    // Storage width of the age field; AGE_W of an allocator must not exceed it.
    localparam int AGE_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } alloc_state_t;

    typedef struct packed {
        logic                 gate;
        logic [NOTE_W-1:0]    note;
        logic [VEL_W-1:0]     vel;
        logic [CH_W-1:0]      chan;
        logic [AGE_MAX_W-1:0] age;
    } voice_t;

endpackage

// File: rtl/voice_alloc_slot.sv
// One voice of the allocator: gate/note/vel/chan registers plus a saturating
// age counter. The age output port exists only when VOICE_STEAL_EN is defined.
module voice_alloc_slot
    import synth_pkg::*;
#(
    parameter int AGE_W = 4
) (
    input  logic                 clk32,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 retrig,
    input  logic                 rel,
    input  logic                 age_inc,
    input  logic [NOTE_W-1:0]    note_i,
    input  logic [VEL_W-1:0]     vel_i,
    input  logic [CH_W-1:0]      chan_i,
`ifdef VOICE_STEAL_EN
    output logic [AGE_MAX_W-1:0] age_o,
`endif
    output logic                 gate_o,
    output logic [NOTE_W-1:0]    note_o,
    output logic [VEL_W-1:0]     vel_o,
    output logic [CH_W-1:0]      chan_o
);

    localparam logic [AGE_MAX_W-1:0] AGE_SAT = AGE_MAX_W'((1 << AGE_W) - 1);

    voice_t voice_q, voice_d;

    always_comb begin
        voice_d = voice_q;
        if (clear) begin
            voice_d.gate = 1'b0;
            voice_d.age  = '0;
        end else if (load) begin
            voice_d.gate = 1'b1;
            voice_d.note = note_i;
            voice_d.vel  = vel_i;
            voice_d.chan = chan_i;
            voice_d.age  = '0;
        end else if (retrig) begin
            voice_d.vel = vel_i;
            voice_d.age = '0;
        end else if (rel) begin
            voice_d.gate = 1'b0;
        end else if (age_inc && voice_q.gate && (voice_q.age != AGE_SAT)) begin
            voice_d.age = voice_q.age + 1'b1;
        end
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            voice_q <= '0;
        end else begin
            voice_q <= voice_d;
        end
    end

    assign gate_o = voice_q.gate;
    assign note_o = voice_q.note;
    assign vel_o  = voice_q.vel;
    assign chan_o = voice_q.chan;
`ifdef VOICE_STEAL_EN
    assign age_o  = voice_q.age;
`endif

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: serial scan of NUM_VOICES slots, then a single
// commit cycle. Oldest-voice stealing is built only when VOICE_STEAL_EN is defined.
module midi_voice_alloc
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 4
) (
    input  logic                         clk32,
    input  logic                         rst,
    input  logic                         note_pressed,
    input  logic                         note_released,
    input  logic [CH_W-1:0]              channel,
    input  logic [NOTE_W-1:0]            note,
    input  logic [VEL_W-1:0]             velocity,
    input  logic                         all_off,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
    output logic [CH_W*NUM_VOICES-1:0]   voice_chan,
    output logic                         busy,
    output logic                         dropped
);

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ev_on_q, ev_on_d;
    logic [NOTE_W-1:0] ev_note_q, ev_note_d;
    logic [VEL_W-1:0]  ev_vel_q, ev_vel_d;
    logic [CH_W-1:0]   ev_chan_q, ev_chan_d;
    logic              match_found_q, match_found_d;
    logic [IDX_W-1:0]  match_idx_q, match_idx_d;
    logic              free_found_q, free_found_d;
    logic [IDX_W-1:0]  free_idx_q, free_idx_d;
    logic              busy_q, busy_d;
    logic              dropped_q, dropped_d;
`ifdef VOICE_STEAL_EN
    logic                 old_found_q, old_found_d;
    logic [IDX_W-1:0]     old_idx_q, old_idx_d;
    logic [AGE_MAX_W-1:0] old_age_q, old_age_d;
    logic [AGE_MAX_W-1:0] age_arr [NUM_VOICES];
`endif

    logic              gate_arr [NUM_VOICES];
    logic [NOTE_W-1:0] note_arr [NUM_VOICES];
    logic [VEL_W-1:0]  vel_arr  [NUM_VOICES];
    logic [CH_W-1:0]   chan_arr [NUM_VOICES];

    logic                  slot_clear;
    logic [NUM_VOICES-1:0] slot_load, slot_retrig, slot_rel;
    logic                  alloc;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  event_in;

    assign event_in = note_pressed | note_released;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        ev_vel_d      = ev_vel_q;
        ev_chan_d     = ev_chan_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
`ifdef VOICE_STEAL_EN
        old_found_d   = old_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
`endif
        dropped_d     = 1'b0;
        slot_clear    = 1'b0;
        slot_load     = '0;
        slot_retrig   = '0;
        slot_rel      = '0;
        alloc         = 1'b0;
        alloc_idx     = '0;

        if (all_off) begin
            slot_clear = 1'b1;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (event_in) begin
                        ev_on_d       = note_pressed && (velocity != '0);
                        ev_note_d     = note;
                        ev_vel_d      = velocity;
                        ev_chan_d     = channel;
                        idx_d         = '0;
                        match_found_d = 1'b0;
                        free_found_d  = 1'b0;
`ifdef VOICE_STEAL_EN
                        old_found_d   = 1'b0;
`endif
                        state_d       = SCAN;
                    end
                end
                SCAN: begin
                    dropped_d = event_in;
                    if (gate_arr[idx_q] && (note_arr[idx_q] == ev_note_q) &&
                        (chan_arr[idx_q] == ev_chan_q) && !match_found_q) begin
                        match_found_d = 1'b1;
                        match_idx_d   = idx_q;
                    end
                    if (!gate_arr[idx_q] && !free_found_q) begin
                        free_found_d = 1'b1;
                        free_idx_d   = idx_q;
                    end
`ifdef VOICE_STEAL_EN
                    // Strict compare keeps the lowest index on equal ages.
                    if (gate_arr[idx_q] && (!old_found_q || (age_arr[idx_q] > old_age_q))) begin
                        old_found_d = 1'b1;
                        old_idx_d   = idx_q;
                        old_age_d   = age_arr[idx_q];
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = COMMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    dropped_d = event_in;
                    state_d   = IDLE;
                    if (ev_on_q) begin
                        if (match_found_q) begin
                            slot_retrig[match_idx_q] = 1'b1;
                            alloc                    = 1'b1;
                            alloc_idx                = match_idx_q;
                        end else if (free_found_q) begin
                            slot_load[free_idx_q] = 1'b1;
                            alloc                 = 1'b1;
                            alloc_idx             = free_idx_q;
                        end
`ifdef VOICE_STEAL_EN
                        else if (old_found_q) begin
                            slot_load[old_idx_q] = 1'b1;
                            alloc                = 1'b1;
                            alloc_idx            = old_idx_q;
                        end
`else
                        else begin
                            dropped_d = 1'b1;
                        end
`endif
                    end else if (match_found_q) begin
                        slot_rel[match_idx_q] = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_vel_q      <= '0;
            ev_chan_q     <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            busy_q        <= 1'b0;
            dropped_q     <= 1'b0;
`ifdef VOICE_STEAL_EN
            old_found_q   <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            ev_vel_q      <= ev_vel_d;
            ev_chan_q     <= ev_chan_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            busy_q        <= busy_d;
            dropped_q     <= dropped_d;
`ifdef VOICE_STEAL_EN
            old_found_q   <= old_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
`endif
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        voice_alloc_slot #(
            .AGE_W(AGE_W)
        ) u_slot (
            .clk32  (clk32),
            .rst    (rst),
            .clear  (slot_clear),
            .load   (slot_load[i]),
            .retrig (slot_retrig[i]),
            .rel    (slot_rel[i]),
            .age_inc(alloc && (alloc_idx != IDX_W'(i))),
            .note_i (ev_note_q),
            .vel_i  (ev_vel_q),
            .chan_i (ev_chan_q),
`ifdef VOICE_STEAL_EN
            .age_o  (age_arr[i]),
`endif
            .gate_o (gate_arr[i]),
            .note_o (note_arr[i]),
            .vel_o  (vel_arr[i]),
            .chan_o (chan_arr[i])
        );

        assign voice_gate[i]                = gate_arr[i];
        assign voice_note[NOTE_W*i +: NOTE_W] = note_arr[i];
        assign voice_vel[VEL_W*i +: VEL_W]    = vel_arr[i];
        assign voice_chan[CH_W*i +: CH_W]     = chan_arr[i];
    end

    assign busy    = busy_q;
    assign dropped = dropped_q;

endmodule
